// File: rtl/contador_pkg.sv
// contador_pkg: shared definitions for the parametrised counters.
//   cnt_dir_e : count direction encodings (CNT_UP=0, CNT_DOWN=1)
//   clog2_f   : ceil(log2(v)), used by counters to check that the width holds the modulus
package contador_pkg;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_m_decode.sv
// contador_m_decode: combinational terminal/midpoint decode for contador_m.
//   q        in  : current count
//   ent      in  : count enable, gates rco/half_rco
//   dir      in  : 0 up, 1 down (ignored unless CONTADOR_M_DOWN_EN is defined)
//   rco      out : ent && q at terminal value
//   half_rco out : ent && q at midpoint (M/2-1 up, M/2 down)
//   wrap     out : q at terminal value, ungated; next step wraps
// Config macro: CONTADOR_M_DOWN_EN
module contador_m_decode
  import contador_pkg::*;
#(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic [N-1:0] q,
  input  logic         ent,
  input  logic         dir,
  output logic         rco,
  output logic         half_rco,
  output logic         wrap
);

  localparam logic [N-1:0] Q_MAX     = N'(M - 1);
  localparam logic [N-1:0] Q_HALF_UP = N'(M / 2 - 1);
  localparam logic [N-1:0] Q_HALF_DN = N'(M / 2);

  logic down;

`ifdef CONTADOR_M_DOWN_EN
  assign down = (cnt_dir_e'(dir) == CNT_DOWN);
`else
  // Up-only build: direction input has no effect.
  logic unused_dir;
  assign unused_dir = dir;
  assign down       = 1'b0;
`endif

  always_comb begin
    wrap     = down ? (q == '0) : (q == Q_MAX);
    rco      = ent && wrap;
    half_rco = ent && (down ? (q == Q_HALF_DN) : (q == Q_HALF_UP));
  end

endmodule

// File: rtl/contador_m.sv
// contador_m: modulo-M binary counter, N bits, 74163-style controls.
//   clock    in  : rising-edge clock
//   clr      in  : async active-low reset (Q=0, fim=0)
//   zera     in  : sync active-low clear, highest synchronous priority
//   ld       in  : sync active-low load; D >= M clamps to M-1
//   ent/enp  in  : count enables, step when both high; ent also gates rco/half_rco
//   dir      in  : 0 up, 1 down (only with CONTADOR_M_DOWN_EN)
//   D        in  : load value
//   Q        out : count, always within 0..M-1
//   rco      out : combinational terminal count
//   half_rco out : combinational midpoint flag
//   fim      out : registered one-cycle pulse after a wrapping step
// Config macro: CONTADOR_M_DOWN_EN enables down counting.
module contador_m
  import contador_pkg::*;
#(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         zera,
  input  logic         ld,
  input  logic         ent,
  input  logic         enp,
  input  logic         dir,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         rco,
  output logic         half_rco,
  output logic         fim
);

  if (M < 2 || N < clog2_f(M)) begin : g_bad_params
    $error("contador_m: need M >= 2 and 2**N >= M (M=%0d N=%0d)", M, N);
  end

  localparam logic [N-1:0] Q_MAX = N'(M - 1);

  logic [N-1:0] q_q, q_d;
  logic         fim_q, fim_d;
  logic         wrap, step;

  contador_m_decode #(.M(M), .N(N)) u_decode (
    .q        (q_q),
    .ent      (ent),
    .dir      (dir),
    .rco      (rco),
    .half_rco (half_rco),
    .wrap     (wrap)
  );

  assign step = ent && enp;

  always_comb begin
    q_d   = q_q;
    fim_d = 1'b0;
    if (!zera) begin
      q_d = '0;
    end else if (!ld) begin
      // Out-of-range load clamps so Q never leaves 0..M-1.
      q_d = (D > Q_MAX) ? Q_MAX : D;
    end else if (step) begin
      // A step taken at the terminal value is the wrap that raises fim next cycle.
      fim_d = wrap;
`ifdef CONTADOR_M_DOWN_EN
      if (cnt_dir_e'(dir) == CNT_DOWN) q_d = wrap ? Q_MAX : q_q - 1'b1;
      else                             q_d = wrap ? '0    : q_q + 1'b1;
`else
      q_d = wrap ? '0 : q_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      q_q   <= '0;
      fim_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      fim_q <= fim_d;
    end
  end

  assign Q   = q_q;
  assign fim = fim_q;

endmodule
